// File: rtl/alu_stateful.sv
// alu_stateful
// Stateful ALU for one action-engine container slot. It runs one sub-action
// at a time (add/sub and their immediate forms, store, load, and an atomic
// load-add-store used for counters) against a private register-array RAM.
//
// Ports:
//   clk                 clock
//   rst_n               asynchronous active-low reset
//   action_in           sub-action word, opcode in the top 4 bits
//   action_valid        action_in and operands are valid
//   action_ready        high only while idle; accept = action_valid & action_ready
//   operand_1_in        op A / store data / loadd increment
//   operand_2_in        op B / RAM address (low ADDR_WIDTH bits)
//   operand_3_in        value returned by a store
//   container_out       result, non-zero only during the valid pulse
//   container_out_valid one-cycle pulse per completed action
module alu_stateful #(
    parameter int DATA_WIDTH = 48,
    parameter int ACTION_LEN = 25,
    parameter int ADDR_WIDTH = 5,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ACTION_LEN-1:0] action_in,
    input  logic                  action_valid,
    output logic                  action_ready,
    input  logic [DATA_WIDTH-1:0] operand_1_in,
    input  logic [DATA_WIDTH-1:0] operand_2_in,
    input  logic [DATA_WIDTH-1:0] operand_3_in,
    output logic [DATA_WIDTH-1:0] container_out,
    output logic                  container_out_valid
);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    localparam logic [3:0] OP_LOADD = 4'b0111;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_EXEC    = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_RMW     = 3'd3;
    localparam logic [2:0] S_OUTPUT  = 3'd4;

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [2:0]            state;
    logic [3:0]            opcode_q;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] op_c;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_phase;

    logic [DATA_WIDTH-1:0] ram [DEPTH];

    logic [3:0]            opcode_in;
    logic                  accept;
    logic [DATA_WIDTH-1:0] exec_result;
    logic [DATA_WIDTH-1:0] rmw_sum;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  unused_bits;

    // Unsigned add/sub shared by add, sub and loadd; SATURATE selects
    // clamping at the ends of the range instead of wrapping.
    function automatic logic [DATA_WIDTH-1:0] do_add(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        logic [DATA_WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (SATURATE != 0 && s[DATA_WIDTH])
            return '1;
        return s[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] do_sub(input logic [DATA_WIDTH-1:0] a,
                                                     input logic [DATA_WIDTH-1:0] b);
        if (SATURATE != 0 && a < b)
            return '0;
        return a - b;
    endfunction

    assign opcode_in    = action_in[ACTION_LEN-1 -: 4];
    assign action_ready = (state == S_IDLE);
    assign accept       = action_valid & action_ready;
    assign unused_bits  = ^action_in[ACTION_LEN-5:0];

    // Result of the single-cycle operations, and the counter update value
    // formed from the word fetched during RD_WAIT.
    always_comb begin
        exec_result = op_c;
        case (opcode_q)
            OP_ADD, OP_ADDI: exec_result = do_add(op_a, op_b);
            OP_SUB, OP_SUBI: exec_result = do_sub(op_a, op_b);
            default:         exec_result = op_c;
        endcase
        rmw_sum = do_add(rd_data, op_a);
    end

    // RAM writes happen only in EXEC (store) or RMW (loadd). Because the
    // enable is decoded from the state, a reset before those states
    // guarantees the write never happens.
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = rmw_sum;
        if (state == S_EXEC && opcode_q == OP_STORE) begin
            ram_we    = 1'b1;
            ram_wdata = op_a;
        end else if (state == S_RMW) begin
            ram_we    = 1'b1;
            ram_wdata = rmw_sum;
        end
    end

    // Register array storage: no reset so contents survive rst_n and the
    // array can map onto RAM primitives.
    always_ff @(posedge clk) begin
        if (ram_we)
            ram[addr_q] <= ram_wdata;
    end

    // Main controller. RD_WAIT takes two cycles: the first registers the
    // read address, the second captures the read data. Outputs are loaded
    // on entry to OUTPUT so the valid pulse coincides with that state and
    // is cleared on the way back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            opcode_q            <= '0;
            op_a                <= '0;
            op_b                <= '0;
            op_c                <= '0;
            addr_q              <= '0;
            rd_addr             <= '0;
            rd_data             <= '0;
            rd_phase            <= 1'b0;
            container_out       <= '0;
            container_out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        opcode_q <= opcode_in;
                        op_a     <= operand_1_in;
                        op_b     <= operand_2_in;
                        op_c     <= operand_3_in;
                        addr_q   <= operand_2_in[ADDR_WIDTH-1:0];
                        case (opcode_in)
                            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_STORE: state <= S_EXEC;
                            OP_LOAD, OP_LOADD:                          state <= S_RD_WAIT;
                            default:                                    state <= S_IDLE;
                        endcase
                    end
                end
                S_EXEC: begin
                    container_out       <= exec_result;
                    container_out_valid <= 1'b1;
                    state               <= S_OUTPUT;
                end
                S_RD_WAIT: begin
                    if (!rd_phase) begin
                        rd_addr  <= addr_q;
                        rd_phase <= 1'b1;
                    end else begin
                        rd_phase <= 1'b0;
                        rd_data  <= ram[rd_addr];
                        if (opcode_q == OP_LOADD) begin
                            state <= S_RMW;
                        end else begin
                            container_out       <= ram[rd_addr];
                            container_out_valid <= 1'b1;
                            state               <= S_OUTPUT;
                        end
                    end
                end
                S_RMW: begin
                    container_out       <= rmw_sum;
                    container_out_valid <= 1'b1;
                    state               <= S_OUTPUT;
                end
                S_OUTPUT: begin
                    container_out       <= '0;
                    container_out_valid <= 1'b0;
                    opcode_q            <= '0;
                    op_a                <= '0;
                    op_b                <= '0;
                    op_c                <= '0;
                    addr_q              <= '0;
                    rd_addr             <= '0;
                    rd_data             <= '0;
                    state               <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_stateful.sv
// tb_alu_stateful
// Self-checking bench for alu_stateful. Two instances share all inputs: one
// wrapping (SATURATE=0) and one clamping (SATURATE=1). A transaction-level
// model (plain arithmetic on 64-bit integers plus one array per RAM) predicts
// result, latency and ready behaviour for directed cases and random traffic.
//
// Ports: none (top-level bench).
module tb_alu_stateful;

    localparam longint unsigned MAX = 64'h0000_FFFF_FFFF_FFFF;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LOAD  = 4'b1011;
    localparam logic [3:0] OP_LOADD = 4'b0111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] action_in;
    logic        action_valid;
    logic [47:0] operand_1_in;
    logic [47:0] operand_2_in;
    logic [47:0] operand_3_in;
    logic [47:0] out0, out1;
    logic        vld0, vld1, rdy0, rdy1;

    int checks = 0;
    int errors = 0;

    // Reference RAM contents for each instance; known[] marks addresses
    // written since power-up (anything else is undefined).
    longint unsigned ram0 [32];
    longint unsigned ram1 [32];
    bit              known [32];

    alu_stateful #(.DATA_WIDTH(48), .ACTION_LEN(25), .ADDR_WIDTH(5), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
        .action_ready(rdy0), .operand_1_in(operand_1_in), .operand_2_in(operand_2_in),
        .operand_3_in(operand_3_in), .container_out(out0), .container_out_valid(vld0));

    alu_stateful #(.DATA_WIDTH(48), .ACTION_LEN(25), .ADDR_WIDTH(5), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .action_in(action_in), .action_valid(action_valid),
        .action_ready(rdy1), .operand_1_in(operand_1_in), .operand_2_in(operand_2_in),
        .operand_3_in(operand_3_in), .container_out(out1), .container_out_valid(vld1));

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Hard stop in case something upstream hangs the bench.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint unsigned modelAdd(input longint unsigned a, input longint unsigned b,
                                                 input bit sat);
        longint unsigned s;
        s = a + b;
        if (s > MAX) s = sat ? MAX : s - (MAX + 1);
        return s;
    endfunction

    function automatic longint unsigned modelSub(input longint unsigned a, input longint unsigned b,
                                                 input bit sat);
        if (a >= b) return a - b;
        return sat ? 64'd0 : a + (MAX + 1) - b;
    endfunction

    function automatic logic [47:0] rand48();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       return 48'(MAX - 64'($urandom_range(0, 3)));
            1:       return 48'($urandom_range(0, 15));
            default: return r[47:0];
        endcase
    endfunction

    task automatic checkOutput(input string tag, input longint unsigned actual,
                               input longint unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Issues one action starting at a falling edge, then follows it to the
    // falling edge after its valid pulse, checking result, latency and
    // ready. Returns at a falling edge with the DUTs idle, so consecutive
    // calls accept on the earliest legal edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [47:0] a,
                                 input logic [47:0] b, input logic [47:0] c);
        int              lat;
        int              addr;
        int              lowcnt;
        bit              seen;
        bit              has_out;
        bit              val_known;
        longint unsigned e0, e1;
        logic [20:0]     junk;

        addr      = int'(b[4:0]);
        lat       = 0;
        has_out   = 1'b1;
        val_known = 1'b1;
        e0        = 0;
        e1        = 0;
        case (op)
            OP_ADD, OP_ADDI: begin
                lat = 2; e0 = modelAdd(a, b, 1'b0); e1 = modelAdd(a, b, 1'b1);
            end
            OP_SUB, OP_SUBI: begin
                lat = 2; e0 = modelSub(a, b, 1'b0); e1 = modelSub(a, b, 1'b1);
            end
            OP_STORE: begin
                lat = 2; e0 = c; e1 = c;
                ram0[addr] = a; ram1[addr] = a; known[addr] = 1'b1;
            end
            OP_LOAD: begin
                lat = 3; e0 = ram0[addr]; e1 = ram1[addr]; val_known = known[addr];
            end
            OP_LOADD: begin
                lat = 4; val_known = known[addr];
                if (val_known) begin
                    e0 = modelAdd(ram0[addr], a, 1'b0);
                    e1 = modelAdd(ram1[addr], a, 1'b1);
                    ram0[addr] = e0; ram1[addr] = e1;
                end
            end
            default: has_out = 1'b0;
        endcase

        checkOutput("ready_at_issue", rdy0 & rdy1, 1);
        junk         = 21'($urandom);
        action_in    = {op, junk};
        action_valid = 1'b1;
        operand_1_in = a;
        operand_2_in = b;
        operand_3_in = c;
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        operand_1_in = rand48();
        operand_2_in = rand48();
        operand_3_in = rand48();

        if (!has_out) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checkOutput("badop_valid", {vld1, vld0}, 0);
                checkOutput("badop_ready", rdy0 & rdy1, 1);
            end
            return;
        end

        seen   = 1'b0;
        lowcnt = 0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            if (!rdy0) lowcnt++;
            if (vld0) begin
                seen = 1'b1;
                checkOutput("latency", cyc, lat);
                checkOutput("valid_sat", vld1, 1);
                if (val_known) begin
                    checkOutput("result_wrap", out0, e0);
                    checkOutput("result_sat", out1, e1);
                end
                break;
            end
        end
        if (!seen) checkOutput("valid_timeout", 0, 1);
        checkOutput("ready_low_cycles", lowcnt, lat);

        @(negedge clk);
        checkOutput("post_valid", {vld1, vld0}, 0);
        checkOutput("post_out_wrap", out0, 0);
        checkOutput("post_out_sat", out1, 0);
    endtask

    logic [3:0] op_table [10];
    logic [3:0] rop;
    bit         pulse_seen;

    initial begin
        op_table[0] = OP_ADD;   op_table[1] = OP_ADDI;  op_table[2] = OP_SUB;
        op_table[3] = OP_SUBI;  op_table[4] = OP_STORE; op_table[5] = OP_LOAD;
        op_table[6] = OP_LOADD; op_table[7] = 4'b1111;  op_table[8] = 4'b0000;
        op_table[9] = OP_LOADD;
        for (int i = 0; i < 32; i++) begin
            ram0[i] = 0; ram1[i] = 0; known[i] = 1'b0;
        end

        rst_n        = 1'b0;
        action_in    = '0;
        action_valid = 1'b0;
        operand_1_in = '0;
        operand_2_in = '0;
        operand_3_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_out", {out1, out0}, 0);
        checkOutput("reset_valid", {vld1, vld0}, 0);
        checkOutput("reset_ready", {rdy1, rdy0}, 2'b11);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(OP_ADDI, 48'd5, 48'd7, 48'd0);
        applyStimulus(OP_STORE, 48'hABCD, 48'h23, 48'h11);
        applyStimulus(OP_LOAD, 48'd0, 48'h03, 48'd0);
        applyStimulus(OP_STORE, 48'd9, 48'd4, 48'd0);
        applyStimulus(OP_LOADD, 48'd1, 48'd4, 48'd0);
        applyStimulus(OP_LOADD, 48'd1, 48'd4, 48'd0);
        applyStimulus(OP_LOAD, 48'd0, 48'd4, 48'd0);
        applyStimulus(OP_ADD, 48'hFFFF_FFFF_FFFF, 48'd1, 48'd0);
        applyStimulus(OP_SUB, 48'd3, 48'd5, 48'd0);
        applyStimulus(4'b1111, 48'd2, 48'd2, 48'd0);
        applyStimulus(OP_ADD, 48'd2, 48'd2, 48'd0);

        $display("[TB] reset during loadd");
        applyStimulus(OP_STORE, 48'd20, 48'd6, 48'd0);
        action_in    = {OP_LOADD, 21'd0};
        action_valid = 1'b1;
        operand_1_in = 48'd1;
        operand_2_in = 48'd6;
        @(posedge clk);
        #1;
        action_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out", {out1, out0}, 0);
        checkOutput("midreset_valid", {vld1, vld0}, 0);
        checkOutput("midreset_ready", {rdy1, rdy0}, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        pulse_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (vld0 | vld1) pulse_seen = 1'b1;
        end
        checkOutput("midreset_no_pulse", pulse_seen, 0);
        applyStimulus(OP_LOAD, 48'd0, 48'd6, 48'd0);

        $display("[TB] filling RAM");
        for (int i = 0; i < 32; i++)
            applyStimulus(OP_STORE, rand48(), {43'($urandom), 5'(i)}, rand48());

        $display("[TB] random traffic");
        for (int n = 0; n < 200; n++) begin
            rop = op_table[$urandom_range(0, 9)];
            applyStimulus(rop, rand48(), rand48(), rand48());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
